// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (REQ/WAIT/HOLD) with
// redirect handling and dropping of a stale in-flight response.
module ysyx_22041207_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [63:0] pc_reg;
  logic [63:0] fetch_pc;
  logic        drop;
  logic [63:0] target;

  assign target         = {redirect_pc[63:2], 2'b00};
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_addr      = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc_reg     <= RESET_PC;
      fetch_pc   <= '0;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_o     <= '0;
      pc_o       <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state    <= S_WAIT;
            fetch_pc <= pc_reg;
          end
          if (redirect_valid) begin
            pc_reg <= target;
            // the request accepted this edge still targets the old pc
            if (imem_req_ready) drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_reg <= target;
            if (imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst_o     <= imem_rsp_data;
              pc_o       <= fetch_pc;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc_reg     <= target;
            state      <= S_REQ;
          end else if (!stall) begin
            inst_valid <= 1'b0;
            pc_reg     <= pc_reg + 64'd4;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Vector table + scoreboard bench for the fetch unit; every step's expected
// post-edge outputs are queued on drive and popped after the edge.
module tb_ysyx_22041207_ifu;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [63:0] pc_o;

  ysyx_22041207_ifu dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_o(inst_o), .pc_o(pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [63:0] addr;
    logic        iv;
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic        rst, stall, rdv;
    logic [63:0] rpc;
    logic        rdy, rspv;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  localparam logic [63:0] A = 64'h0000_0000_8000_0000;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic st, logic rdv, logic [63:0] rpc,
                              logic rdy, logic rspv, logic [31:0] rdata,
                              logic erv, logic [63:0] eaddr, logic eiv,
                              logic [31:0] einst, logic [63:0] epc);
    vec_t v;
    v.rst = r; v.stall = st; v.rdv = rdv; v.rpc = rpc;
    v.rdy = rdy; v.rspv = rspv; v.rdata = rdata;
    v.e.rv = erv; v.e.addr = eaddr; v.e.iv = eiv; v.e.inst = einst; v.e.pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  // drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; stall = v.stall; redirect_valid = v.rdv; redirect_pc = v.rpc;
    imem_req_ready = v.rdy; imem_rsp_valid = v.rspv; imem_rsp_data = v.rdata;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    chk("req_valid",  {63'd0, imem_req_valid}, {63'd0, e.rv});
    chk("imem_addr",  imem_addr, e.addr);
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, e.iv});
    chk("inst_o",     {32'd0, inst_o}, {32'd0, e.inst});
    chk("pc_o",       pc_o, e.pc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    //            rst st rdv rpc                     rdy rspv rdata          | rv addr                  iv inst           pc
    tbl.push_back(mk(1, 0, 0, 64'd0,                 0, 0, 32'd0,           0, A,                    0, 32'd0,         64'd0));
    tbl.push_back(mk(1, 0, 0, 64'd0,                 1, 1, 32'h1111_1111,   0, A,                    0, 32'd0,         64'd0));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 0, 32'd0,           1, A,                    0, 32'd0,         64'd0));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 1, 0, 32'd0,           0, A,                    0, 32'd0,         64'd0));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'h0000_0013,   0, A,                    1, 32'h13,        A));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 0, 64'd0,               0, 0, 32'd0,           0, A,                    1, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 0, 32'd0,           1, A + 4,                0, 32'h13,        A));
    // ready low for three cycles; response pulses in REQ are ignored
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'h1234_5678,   1, A + 4,                0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'h1234_5678,   1, A + 4,                0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 0, 32'd0,           1, A + 4,                0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 1, 0, 32'd0,           0, A + 4,                0, 32'h13,        A));
    // redirect in WAIT, then the stale response is dropped
    tbl.push_back(mk(0, 0, 1, 64'h8000_0103,         0, 0, 32'd0,           0, 64'h8000_0100,        0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'hDEAD_BEEF,   1, 64'h8000_0100,        0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 1, 0, 32'd0,           0, 64'h8000_0100,        0, 32'h13,        A));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'h0010_0093,   0, 64'h8000_0100,        1, 32'h0010_0093, 64'h8000_0100));
    // redirect in HOLD beats stall
    tbl.push_back(mk(0, 1, 1, 64'h8000_0200,         0, 0, 32'd0,           1, 64'h8000_0200,        0, 32'h0010_0093, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 1, 64'h8000_0300,         0, 0, 32'd0,           1, 64'h8000_0300,        0, 32'h0010_0093, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 1, 64'h8000_0400,         1, 0, 32'd0,           0, 64'h8000_0400,        0, 32'h0010_0093, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 1, 64'h8000_0500,         0, 1, 32'hBAD0_0001,   1, 64'h8000_0500,        0, 32'h0010_0093, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 1, 0, 32'd0,           0, 64'h8000_0500,        0, 32'h0010_0093, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 1, 32'hAAAA_5555,   0, 64'h8000_0500,        1, 32'hAAAA_5555, 64'h8000_0500));
    tbl.push_back(mk(0, 0, 0, 64'd0,                 0, 0, 32'd0,           1, 64'h8000_0504,        0, 32'hAAAA_5555, 64'h8000_0500));

    foreach (tbl[i]) step(tbl[i]);

    // PC wrap at the top of the address space
    step(mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hAAAA_5555, 64'h8000_0500));
    step(mk(0, 0, 0, 64'd0, 1, 0, 32'd0,          0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hAAAA_5555, 64'h8000_0500));
    step(mk(0, 0, 0, 64'd0, 0, 1, 32'h13,         0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h13, 64'hFFFF_FFFF_FFFF_FFFC));
    step(mk(0, 0, 0, 64'd0, 0, 0, 32'd0,          1, 64'd0, 0, 32'h13, 64'hFFFF_FFFF_FFFF_FFFC));

    // reset with a request outstanding; the late response is ignored
    step(mk(0, 0, 0, 64'd0, 1, 0, 32'd0,          0, 64'd0, 0, 32'h13, 64'hFFFF_FFFF_FFFF_FFFC));
    step(mk(1, 0, 0, 64'd0, 0, 0, 32'd0,          0, A, 0, 32'd0, 64'd0));
    step(mk(0, 0, 0, 64'd0, 0, 1, 32'h0BAD_0BAD,  1, A, 0, 32'd0, 64'd0));

    // back-to-back redirects in WAIT: latest wins, one response dropped
    step(mk(0, 0, 0, 64'd0,         1, 0, 32'd0,         0, A, 0, 32'd0, 64'd0));
    step(mk(0, 0, 1, 64'h8000_0600, 0, 0, 32'd0,         0, 64'h8000_0600, 0, 32'd0, 64'd0));
    step(mk(0, 0, 1, 64'h8000_0702, 0, 0, 32'd0,         0, 64'h8000_0700, 0, 32'd0, 64'd0));
    step(mk(0, 0, 0, 64'd0,         0, 1, 32'h0BAD_0BAD, 1, 64'h8000_0700, 0, 32'd0, 64'd0));
    step(mk(0, 0, 0, 64'd0,         1, 0, 32'd0,         0, 64'h8000_0700, 0, 32'd0, 64'd0));
    step(mk(0, 0, 0, 64'd0,         0, 1, 32'h0000_0013, 0, 64'h8000_0700, 1, 32'h13, 64'h8000_0700));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_ifu.md
YSYX_22041207_IFU -- requirements
Module: ysyx_22041207_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall  input  1  SHALL mean downstream (IF/ID) cannot accept the presented instruction this cycle.
REQ-005 redirect_valid  input  1  SHALL mean a branch, jump or exception redirect is requested this cycle.
REQ-006 redirect_pc  input  64  SHALL be the redirect target.
REQ-007 imem_req_valid  output  1  SHALL mean the fetch request is valid.
REQ-008 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-009 imem_addr  output  64  SHALL be the fetch address.
REQ-010 imem_rsp_valid  input  1  SHALL mean imem_rsp_data is valid this cycle.
REQ-011 imem_rsp_data  input  32  SHALL be the fetched instruction word.
REQ-012 inst_valid  output  1  SHALL mean inst_o and pc_o hold a deliverable instruction.
REQ-013 inst_o  output  32  SHALL be the registered instruction.
REQ-014 pc_o  output  64  SHALL be the registered PC of inst_o.

Function
REQ-015 The FSM SHALL have three states: REQ, WAIT and HOLD.
REQ-016 In REQ: imem_req_valid=1 and imem_addr=pc_reg (combinational from state); in WAIT and HOLD imem_req_valid SHALL be 0.
REQ-017 REQ, req_ready=1 -> WAIT, latching fetch_pc<=pc_reg; req_ready=0 -> stay REQ with imem_addr unchanged unless redirected.
REQ-018 WAIT, rsp_valid=1, drop=0 -> HOLD; inst_o<=rsp_data, pc_o<=fetch_pc and inst_valid<=1, all in the same edge.
REQ-019 WAIT, rsp_valid=1, drop=1 -> REQ; clear drop; outputs unchanged, inst_valid stays 0.
REQ-020 WAIT, rsp_valid=0 -> stay WAIT.
REQ-021 HOLD, stall=1 -> stay HOLD; inst_o, pc_o and inst_valid=1 held stable.
REQ-022 HOLD, stall=0 -> REQ; inst_valid<=0, pc_reg<=pc_reg+4.
REQ-023 A delivered instruction is consumed exactly in a cycle with inst_valid=1 and stall=0.
REQ-024 Redirect target SHALL be loaded as {redirect_pc[63:2],2'b00}.
REQ-025 Redirect SHALL take priority over stall and over normal PC increment.
REQ-026 Redirect in REQ with req_ready=0: pc_reg<=target; stay REQ.
REQ-027 Redirect in REQ with req_ready=1: pc_reg<=target, drop<=1, go WAIT.
REQ-028 Redirect in WAIT with rsp_valid=0: pc_reg<=target, drop<=1, stay WAIT.
REQ-029 Redirect in WAIT with rsp_valid=1: the response is discarded, pc_reg<=target, drop<=0, go REQ.
REQ-030 Redirect in HOLD: inst_valid<=0, pc_reg<=target, go REQ; the held instruction is never consumed.
REQ-031 Back-to-back redirects: the latest target wins; at most one in-flight response is dropped.
REQ-032 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-033 PC arithmetic SHALL be 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC+4 = 0.
REQ-034 At most one request SHALL be outstanding at any time.

Reset
REQ-035 While rst=1: state=REQ, pc_reg=RESET_PC, drop=0, inst_valid=0, inst_o=0, pc_o=0, imem_req_valid=0.
REQ-036 In the first cycle after rst deasserts: imem_req_valid=1 and imem_addr=RESET_PC.
REQ-037 Reset asserted in any state, including WAIT with a request outstanding, SHALL return to the REQ-035 state on the next edge.
REQ-038 A response arriving after reset for a pre-reset request SHALL be ignored.

Verification
REQ-039 Reset, then ready=1 and response one cycle later with 32'h00000013 -> inst_valid=1, pc_o=8000_0000; next fetch address 8000_0004.
REQ-040 HOLD with stall=1 for 5 cycles -> outputs stable for 5 cycles and no request issued; stall=0 -> request at pc+4 on the following cycle.
REQ-041 Redirect to 64'h8000_0103 while in WAIT, then response 32'hDEADBEEF -> response dropped, inst_valid stays 0, next request address 8000_0100.
REQ-042 Redirect to 8000_0200 in HOLD with stall=1 -> inst_valid=0 next cycle, then request at 8000_0200.
REQ-043 req_ready=0 for 3 cycles -> imem_addr held stable and req_valid stays 1; rsp_valid pulses while in REQ are ignored.
REQ-044 pc_reg=FFFF_FFFF_FFFF_FFFC, instruction consumed -> next request address 0.
